// File: rtl/glbl_cfg_pkg.sv
// Shared constants, register-map offsets and bus types for the global config bank.
package glbl_cfg_pkg;

  // Byte that must be written to LOCK[7:0] to open the CFG words for writing.
  localparam logic [7:0] UNLOCK_KEY = 8'hA5;

  // Word offsets of the fixed registers, relative to the first word after the CFG array.
  localparam int unsigned OFS_INT_STAT = 0;
  localparam int unsigned OFS_INT_MASK = 1;
  localparam int unsigned OFS_LOCK     = 2;
  localparam int unsigned OFS_ID       = 3;
  localparam int unsigned OFS_DATE     = 4;
  localparam int unsigned OFS_REV      = 5;

  // One reg-bus request as seen by the bank.
  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } reg_req_t;

  // Handshake sequencer: IDLE accepts, ACK is the one-cycle acknowledge,
  // HOLD waits for the master to drop cs so a held request commits once.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_ACK  = 2'd1,
    HS_HOLD = 2'd2
  } hs_state_t;

  // Expand four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gen_32b_reg.sv
// Generic 32-bit register with per-byte write enables and a parametrised reset value.
module gen_32b_reg
  import glbl_cfg_pkg::*;
#(
  parameter logic [31:0] RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  // Merge enabled bytes of wdata into the stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else if (we) begin
      q <= (q & ~be_mask(be)) | (wdata & be_mask(be));
    end
  end

endmodule

// File: rtl/glbl_int_ctrl.sv
// Interrupt block: event detection, sticky write-1-to-clear status, mask and registered irq.
module glbl_int_ctrl #(
  parameter int INT_W    = 8,
  parameter int INT_EDGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] int_src,
  input  logic             stat_we,
  input  logic             mask_we,
  input  logic [INT_W-1:0] wmask,
  input  logic [INT_W-1:0] wbits,
  output logic [31:0]      stat,
  output logic [31:0]      mask,
  output logic             irq
);

  logic [INT_W-1:0] src_q;
  logic [INT_W-1:0] set_ev;
  logic [INT_W-1:0] clr;
  logic [INT_W-1:0] stat_q;
  logic [INT_W-1:0] mask_q;

  // Events: rising edge in edge mode, raw level in level mode.
  assign set_ev = (INT_EDGE != 0) ? (int_src & ~src_q) : int_src;
  assign clr    = stat_we ? wbits : '0;

  // Status, mask, edge history and irq flops; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      src_q  <= int_src;
      stat_q <= (stat_q & ~clr) | set_ev;
      if (mask_we) begin
        mask_q <= (mask_q & ~wmask) | wbits;
      end
      irq    <= |(stat_q & mask_q);
    end
  end

  // Zero-extend to bus width; bits at and above INT_W read as 0.
  always_comb begin
    stat              = '0;
    mask              = '0;
    stat[INT_W-1:0]   = stat_q;
    mask[INT_W-1:0]   = mask_q;
  end

endmodule

// File: rtl/glbl_cfg_bank.sv
// Global config/status register bank: NUM_CFG lockable RW words, interrupt
// status/mask, write-lock key and read-only identification words.
// Handshake: a request is taken when reg_cs is high in IDLE; the following
// cycle reg_ack pulses once with reg_rdata (old word contents) and reg_err.
// The master must drop reg_cs after seeing reg_ack before the next request.
module glbl_cfg_bank
  import glbl_cfg_pkg::*;
#(
  parameter int                    NUM_CFG  = 8,
  parameter logic [NUM_CFG*32-1:0] CFG_RST  = '0,
  parameter int                    INT_W    = 8,
  parameter int                    INT_EDGE = 1,
  parameter logic [31:0]           CHIP_ID  = 32'h4C66_8354,
  parameter logic [31:0]           REL_DATE = 32'h1603_2022,
  parameter logic [31:0]           REV      = 32'h0001_6000
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic                  reg_cs,
  input  logic                  reg_wr,
  input  logic [7:0]            reg_addr,
  input  logic [31:0]           reg_wdata,
  input  logic [3:0]            reg_be,
  output logic [31:0]           reg_rdata,
  output logic                  reg_ack,
  output logic                  reg_err,
  input  logic [INT_W-1:0]      int_src,
  output logic [NUM_CFG*32-1:0] cfg_out,
  output logic                  irq
);

  localparam logic [5:0] IDX_STAT = 6'(NUM_CFG + OFS_INT_STAT);
  localparam logic [5:0] IDX_MASK = 6'(NUM_CFG + OFS_INT_MASK);
  localparam logic [5:0] IDX_LOCK = 6'(NUM_CFG + OFS_LOCK);
  localparam logic [5:0] IDX_ID   = 6'(NUM_CFG + OFS_ID);
  localparam logic [5:0] IDX_DATE = 6'(NUM_CFG + OFS_DATE);
  localparam logic [5:0] IDX_REV  = 6'(NUM_CFG + OFS_REV);

  reg_req_t         req;
  hs_state_t        state;
  hs_state_t        state_nxt;
  logic             accept;
  logic             wr_en;
  logic [5:0]       idx;
  logic             unused_addr_lsb;
  logic             lock;
  logic [NUM_CFG-1:0] cfg_we;
  logic [31:0]      rd_data;
  logic             rd_err;
  logic [31:0]      int_stat;
  logic [31:0]      int_mask;
  logic [INT_W-1:0] int_wmask;
  logic [INT_W-1:0] int_wbits;

  assign req             = '{cs: reg_cs, wr: reg_wr, addr: reg_addr, wdata: reg_wdata, be: reg_be};
  assign idx             = req.addr[7:2];
  assign unused_addr_lsb = ^req.addr[1:0];
  assign wr_en           = accept & req.wr;

  // Handshake state register.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake next state: one ack per request, then wait for cs to drop.
  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE: if (req.cs) state_nxt = HS_ACK;
      HS_ACK:  state_nxt = req.cs ? HS_HOLD : HS_IDLE;
      HS_HOLD: if (!req.cs) state_nxt = HS_IDLE;
      default: state_nxt = HS_IDLE;
    endcase
  end

  // Handshake outputs: accept strobe and the ack decoded from the state flop.
  always_comb begin
    accept  = (state == HS_IDLE) && req.cs;
    reg_ack = (state == HS_ACK);
  end

  // Capture read data and error status on the accepting edge.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata <= '0;
      reg_err   <= 1'b0;
    end else begin
      if (accept) begin
        reg_rdata <= rd_data;
      end
      reg_err <= accept ? rd_err : 1'b0;
    end
  end

  // Lock: only the unlock key clears it; any other byte-0 write sets it.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      lock <= 1'b1;
    end else if (wr_en && (idx == IDX_LOCK) && req.be[0]) begin
      lock <= (req.wdata[7:0] != UNLOCK_KEY);
    end
  end

  // Read mux and error decode for the addressed word.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (idx < IDX_STAT) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (idx == 6'(i)) rd_data = cfg_out[32*i +: 32];
      end
      rd_err = req.wr & lock;
    end else if (idx == IDX_STAT) begin
      rd_data = int_stat;
    end else if (idx == IDX_MASK) begin
      rd_data = int_mask;
    end else if (idx == IDX_LOCK) begin
      rd_data = {31'b0, lock};
    end else if (idx == IDX_ID) begin
      rd_data = CHIP_ID;
      rd_err  = req.wr;
    end else if (idx == IDX_DATE) begin
      rd_data = REL_DATE;
      rd_err  = req.wr;
    end else if (idx == IDX_REV) begin
      rd_data = REV;
      rd_err  = req.wr;
    end else begin
      rd_err  = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg_we[g] = wr_en & ~lock & (idx == 6'(g));
    gen_32b_reg #(.RST(CFG_RST[32*g +: 32])) u_reg (
      .clk   (mclk),
      .rst_n (reset_n),
      .we    (cfg_we[g]),
      .be    (req.be),
      .wdata (req.wdata),
      .q     (cfg_out[32*g +: 32])
    );
  end

  for (genvar b = 0; b < INT_W; b++) begin : g_intw
    assign int_wmask[b] = req.be[b/8];
    assign int_wbits[b] = req.wdata[b] & req.be[b/8];
  end

  glbl_int_ctrl #(.INT_W(INT_W), .INT_EDGE(INT_EDGE)) u_int (
    .clk     (mclk),
    .rst_n   (reset_n),
    .int_src (int_src),
    .stat_we (wr_en && (idx == IDX_STAT)),
    .mask_we (wr_en && (idx == IDX_MASK)),
    .wmask   (int_wmask),
    .wbits   (int_wbits),
    .stat    (int_stat),
    .mask    (int_mask),
    .irq     (irq)
  );

endmodule

// File: tb/tb_glbl_cfg_bank.sv
// Self-checking bench for glbl_cfg_bank: edge-mode instance on the bus plus a
// level-mode instance sharing the bus for the level-interrupt behaviour.
module tb_glbl_cfg_bank;

  localparam int NUM_CFG = 8;
  localparam int INT_W   = 8;
  localparam logic [255:0] CFG_RST_TB = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                         32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'h00000000};
  localparam logic [31:0] ID_V   = 32'h4C668354;
  localparam logic [31:0] DATE_V = 32'h16032022;
  localparam logic [31:0] REV_V  = 32'h00016000;

  // clock / reset block
  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 mclk = ~mclk;

  logic             reg_cs = 1'b0;
  logic             reg_wr = 1'b0;
  logic [7:0]       reg_addr = '0;
  logic [31:0]      reg_wdata = '0;
  logic [3:0]       reg_be = '0;
  logic [31:0]      rdata1, rdata2;
  logic             ack1, ack2, err1, err2, irq1, irq2;
  logic [INT_W-1:0] src1 = '0;
  logic [INT_W-1:0] src2 = '0;
  logic [255:0]     cfg1, cfg2;

  glbl_cfg_bank #(.NUM_CFG(NUM_CFG), .CFG_RST(CFG_RST_TB), .INT_W(INT_W), .INT_EDGE(1)) dut (
    .mclk(mclk), .reset_n(reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(rdata1), .reg_ack(ack1), .reg_err(err1),
    .int_src(src1), .cfg_out(cfg1), .irq(irq1));

  glbl_cfg_bank #(.NUM_CFG(NUM_CFG), .CFG_RST(CFG_RST_TB), .INT_W(INT_W), .INT_EDGE(0)) dut_lvl (
    .mclk(mclk), .reset_n(reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(rdata2), .reg_ack(ack2), .reg_err(err2),
    .int_src(src2), .cfg_out(cfg2), .irq(irq2));

  // scoreboard
  logic [31:0] exp_q[$];
  logic        err_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  // reference model
  logic [31:0] cfg_m[NUM_CFG];
  logic        lock_m;
  logic [31:0] stat_m;
  logic [31:0] mask_m;
  logic [31:0] rd2_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CFG; i++) cfg_m[i] = CFG_RST_TB[32*i +: 32];
    lock_m = 1'b1;
    stat_m = '0;
    mask_m = '0;
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    if (idx < NUM_CFG) return cfg_m[idx];
    if (idx == 8)  return stat_m;
    if (idx == 9)  return mask_m;
    if (idx == 10) return {31'b0, lock_m};
    if (idx == 11) return ID_V;
    if (idx == 12) return DATE_V;
    if (idx == 13) return REV_V;
    return 32'h0;
  endfunction

  function automatic logic model_err(input logic wr, input int idx);
    if (idx < NUM_CFG) return wr & lock_m;
    if (idx <= 10)     return 1'b0;
    if (idx <= 13)     return wr;
    return 1'b1;
  endfunction

  task automatic model_wr(input int idx, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] bm;
    bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (idx < NUM_CFG) begin
      if (!lock_m) cfg_m[idx] = (cfg_m[idx] & ~bm) | (wd & bm);
    end else if (idx == 8) begin
      stat_m = stat_m & ~(wd & bm);
    end else if (idx == 9) begin
      mask_m = ((mask_m & ~bm) | (wd & bm)) & 32'h000000FF;
    end else if (idx == 10) begin
      if (be[0]) lock_m = (wd[7:0] != 8'hA5);
    end
  endtask

  // driver: one bus transaction; pulse bits of src1 are high only over the accepting edge
  task automatic bus_xfer(input logic wr, input int idx, input logic [31:0] wd,
                          input logic [3:0] be, input logic [INT_W-1:0] pulse);
    logic [31:0] e;
    logic        ee;
    int          n;
    exp_q.push_back(model_rd(idx));
    err_q.push_back(model_err(wr, idx));
    if (wr) model_wr(idx, wd, be);
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = wr; reg_addr = {idx[5:0], 2'b00}; reg_wdata = wd; reg_be = be;
    src1 = src1 | pulse;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
      src1 = src1 & ~pulse;
    end while (!ack1 && n < 16);
    e  = exp_q.pop_front();
    ee = err_q.pop_front();
    if (!ack1) begin
      chk("ack_timeout", {31'b0, ack1}, 32'd1);
    end else begin
      chk($sformatf("rdata_w%0d", idx), rdata1, e);
      chk($sformatf("err_w%0d", idx), {31'b0, err1}, {31'b0, ee});
      chk("ack_lvl", {31'b0, ack2}, 32'd1);
      chk("err_lvl", {31'b0, err2}, {31'b0, ee});
    end
    rd2_last = rdata2;
    reg_cs = 1'b0; reg_wr = 1'b0;
    @(negedge mclk);
    chk("ack_drop", {31'b0, ack1}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    reg_cs = 1'b0; reg_wr = 1'b0; src1 = '0; src2 = '0;
    model_reset();
    repeat (3) @(negedge mclk);
    chk("rst_ack", {31'b0, ack1}, 32'd0);
    chk("rst_err", {31'b0, err1}, 32'd0);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_irq", {30'b0, irq2, irq1}, 32'd0);
    for (int i = 0; i < NUM_CFG; i++) chk($sformatf("rst_cfg%0d", i), cfg1[32*i +: 32], CFG_RST_TB[32*i +: 32]);
    chk("rst_cfg_lvl", cfg2[31:0], 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] e;
    logic        ee;
    int          acks;
    int          n;

    do_reset();
    for (int i = 0; i < 15; i++) bus_xfer(1'b0, i, 32'h0, 4'h0, '0);

    // locked write, unlock, byte-enabled write
    bus_xfer(1'b1, 0, 32'hDEADBEEF, 4'hF, '0);
    bus_xfer(1'b0, 0, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 10, 32'h000000A5, 4'h1, '0);
    bus_xfer(1'b0, 10, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 0, 32'hDEADBEEF, 4'b0101, '0);
    bus_xfer(1'b0, 0, 32'h0, 4'h0, '0);
    chk("cfg0_bytes", cfg1[31:0], 32'h00AD00EF);
    bus_xfer(1'b1, 3, 32'h12345678, 4'b1000, '0);
    bus_xfer(1'b0, 3, 32'h0, 4'h0, '0);
    chk("cfg3_bytes", cfg1[127:96], 32'h12DE0003);

    // mask with bits beyond INT_W
    bus_xfer(1'b1, 9, 32'hFFFFFF08, 4'hF, '0);
    bus_xfer(1'b0, 9, 32'h0, 4'h0, '0);

    // int_src[3] pulse -> status, irq one cycle later
    @(negedge mclk); src1[3] = 1'b1;
    @(negedge mclk); src1[3] = 1'b0;
    chk("irq_lag", {31'b0, irq1}, 32'd0);
    @(negedge mclk);
    chk("irq_set", {31'b0, irq1}, 32'd1);
    stat_m = stat_m | 32'h08;
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);

    // W1C with cs held: one ack, one commit, re-set during hold survives
    exp_q.push_back(model_rd(8));
    err_q.push_back(1'b0);
    model_wr(8, 32'h08, 4'h1);
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = {6'd8, 2'b00}; reg_wdata = 32'h08; reg_be = 4'h1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge mclk);
      if (ack1) begin
        acks++;
        if (acks == 1) begin
          e  = exp_q.pop_front();
          ee = err_q.pop_front();
          chk("hold_rdata", rdata1, e);
          chk("hold_err", {31'b0, err1}, {31'b0, ee});
        end
      end
      src1[3] = (k == 0);
    end
    if (acks == 0) begin
      e  = exp_q.pop_front();
      ee = err_q.pop_front();
    end
    chk("hold_acks", 32'(acks), 32'd1);
    reg_cs = 1'b0; reg_wr = 1'b0;
    stat_m = stat_m | 32'h08;
    @(negedge mclk);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    chk("irq_hold", {31'b0, irq1}, 32'd1);

    // W1C clears status, irq drops
    bus_xfer(1'b1, 8, 32'h08, 4'h1, '0);
    chk("irq_clr", {31'b0, irq1}, 32'd0);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);

    // set wins over same-cycle clear
    @(negedge mclk); src1[2] = 1'b1;
    @(negedge mclk); src1[2] = 1'b0;
    stat_m = stat_m | 32'h04;
    bus_xfer(1'b1, 8, 32'h04, 4'h1, 8'h04);
    stat_m = stat_m | 32'h04;
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 8, 32'h04, 4'h1, '0);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    chk("irq_unmasked", {31'b0, irq1}, 32'd0);

    // edge mode: held level sets once only
    @(negedge mclk); src1[6] = 1'b1;
    @(negedge mclk);
    stat_m = stat_m | 32'h40;
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 8, 32'h40, 4'h1, '0);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    src1[6] = 1'b0;

    // level mode instance: held source re-sets after clear
    @(negedge mclk); src2[5] = 1'b1;
    @(negedge mclk);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    chk("lvl_stat", rd2_last, 32'h20);
    bus_xfer(1'b1, 8, 32'h20, 4'h1, '0);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    chk("lvl_reset", rd2_last, 32'h20);
    src2[5] = 1'b0;
    @(negedge mclk);
    bus_xfer(1'b1, 8, 32'h20, 4'h1, '0);
    bus_xfer(1'b0, 8, 32'h0, 4'h0, '0);
    chk("lvl_clr", rd2_last, 32'h0);

    // read-only and out-of-range words
    bus_xfer(1'b1, 11, 32'h0, 4'hF, '0);
    bus_xfer(1'b0, 11, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 13, 32'hFFFFFFFF, 4'hF, '0);
    bus_xfer(1'b0, 14, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 14, 32'hFFFFFFFF, 4'hF, '0);
    bus_xfer(1'b0, 15, 32'h0, 4'h0, '0);

    // relock, locked write, lock write without byte 0
    bus_xfer(1'b1, 10, 32'h00000000, 4'h1, '0);
    bus_xfer(1'b1, 1, 32'hFFFFFFFF, 4'hF, '0);
    bus_xfer(1'b0, 1, 32'h0, 4'h0, '0);
    bus_xfer(1'b1, 10, 32'h0000A5A5, 4'h2, '0);
    bus_xfer(1'b0, 10, 32'h0, 4'h0, '0);

    // reset during ack
    bus_xfer(1'b1, 10, 32'h000000A5, 4'h1, '0);
    @(negedge mclk);
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = {6'd1, 2'b00}; reg_wdata = 32'hFFFFFFFF; reg_be = 4'hF;
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!ack1 && n < 16);
    chk("mid_ack", {31'b0, ack1}, 32'd1);
    chk("mid_commit", cfg1[63:32], 32'hFFFFFFFF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", {31'b0, ack1}, 32'd0);
    chk("mid_rst_cfg1", cfg1[63:32], 32'hC0DE0001);
    chk("mid_rst_cfg0", cfg1[31:0], 32'h0);
    chk("mid_rst_rdata", rdata1, 32'h0);
    reg_cs = 1'b0; reg_wr = 1'b0;
    model_reset();
    @(negedge mclk);
    reset_n = 1'b1;
    bus_xfer(1'b0, 10, 32'h0, 4'h0, '0);
    bus_xfer(1'b0, 1, 32'h0, 4'h0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
